// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way cache miss/fill path.
package cache_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WORDS    = 8;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned TAG_W    = 6;
  localparam int unsigned SET_W    = 6;
  localparam int unsigned BLK_W    = TAG_W + SET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  // Block address: everything above the byte-within-block offset.
  function automatic logic [BLK_W-1:0] block_addr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W+1];
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for one side of a block fill; o_word is (start + count) mod 2**CNT_W.
module fill_word_counter
  import cache_pkg::*;
#(
  parameter int unsigned CNT_W = OFFSET_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_start,
  output logic [CNT_W:0]   o_count,
  output logic [CNT_W-1:0] o_word
);

  logic [CNT_W:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_word  = i_start + r_count[CNT_W-1:0];

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block fill controller: streams 8 words from pipelined memory into the victim way.
// Build option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the faulting word.
module cache_fill_ctrl
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                miss,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                stall,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                fill_we,
  output logic [OFFSET_W-1:0] fill_word,
  output logic [DATA_W-1:0]   fill_data,
  output logic                fill_done
);

  fill_state_t         r_state;
  fill_state_t         w_next;
  logic [BLK_W-1:0]    r_blk;
  logic [OFFSET_W-1:0] r_start;
  logic [OFFSET_W-1:0] w_start;
  logic [OFFSET_W:0]   w_issue_cnt;
  logic [OFFSET_W:0]   w_rx_cnt;
  logic [OFFSET_W-1:0] w_issue_word;
  logic [OFFSET_W-1:0] w_rx_word;
  logic                w_idle;
  logic                w_rx_full;
  logic                w_rx_accept;
  logic                w_rx_last;
  logic                w_issue_last;
  logic                w_unused;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign w_start  = miss_addr[OFFSET_W:1];
  assign w_unused = miss_addr[0];
`else
  assign w_start  = '0;
  assign w_unused = ^miss_addr[OFFSET_W:0];
`endif

  assign w_idle       = (r_state == IDLE);
  assign w_rx_full    = w_rx_cnt[OFFSET_W];
  assign w_rx_accept  = mem_valid && !w_idle && !w_rx_full;
  assign w_rx_last    = w_rx_accept && (w_rx_cnt[OFFSET_W-1:0] == '1);
  assign w_issue_last = (w_issue_cnt[OFFSET_W-1:0] == '1);

  fill_word_counter #(.CNT_W(OFFSET_W)) u_issue_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_idle),
    .i_inc   (mem_en),
    .i_start (r_start),
    .o_count (w_issue_cnt),
    .o_word  (w_issue_word)
  );

  fill_word_counter #(.CNT_W(OFFSET_W)) u_rx_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_idle),
    .i_inc   (w_rx_accept),
    .i_start (r_start),
    .o_count (w_rx_cnt),
    .o_word  (w_rx_word)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (miss) w_next = REQ;
      // Final word can land on the last request cycle; skip DRAIN then.
      REQ:     if (w_issue_last) w_next = w_rx_last ? DONE : DRAIN;
      DRAIN:   if (w_rx_last || w_rx_full) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_start <= '0;
    end else begin
      r_state <= w_next;
      if (w_idle && miss) begin
        r_blk   <= block_addr(miss_addr);
        r_start <= w_start;
      end
    end
  end

  // Gating miss with rst keeps stall low while reset is held.
  assign stall     = !w_idle || (miss && rst);
  assign mem_en    = (r_state == REQ);
  assign mem_addr  = mem_en ? {r_blk, w_issue_word, 1'b0} : '0;
  assign fill_we   = w_rx_accept;
  assign fill_word = w_rx_accept ? w_rx_word : '0;
  assign fill_data = mem_data;
  assign fill_done = (r_state == DONE);

endmodule
